// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: turns RV32I R-type ALU and B-type branch requests into
// 32-bit instruction words. Each legal word is tagged with a sequential
// instruction-memory address and held in a 2-entry output FIFO. Illegal
// requests are dropped. They raise a one-cycle err pulse and increment a
// saturating error counter.
//
// Handshake: in_valid/in_ready and out_valid/out_ready are strict
// valid/ready pairs. A transfer happens on a rising edge where both are high.
// A valid source keeps its payload stable until the transfer. in_ready and
// out_valid depend only on the registered FIFO count, so there is no
// combinational path from any in_* signal to any out_* signal.
module rv_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr_clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_kind,
  input  logic [9:0]  in_funct,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_offset,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_count
);

  // FIFO slot 0 is always the head. Slot 1 is valid only when count is 2.
  logic [1:0]  count_q, count_d;
  logic [31:0] instr0_q, instr0_d, instr1_q, instr1_d;
  logic [31:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [31:0] addr_cnt_q, addr_cnt_d;
  logic        err_q, err_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [1:0]  fifo_n;

  logic        r_legal, b_f3_ok, b_off_ok, req_legal;
  logic [12:0] imm;
  logic [31:0] r_word, b_word, enc_word;
  logic        accept, push, pop;

  // R-type legality: the ten {funct7,funct3} codes of the ALU table.
  always_comb begin
    r_legal = 1'b0;
    case (in_funct)
      {7'h00, 3'b000}, // ADD
      {7'h20, 3'b000}, // SUB
      {7'h00, 3'b001}, // SLL
      {7'h00, 3'b010}, // SLT
      {7'h00, 3'b011}, // SLTU
      {7'h00, 3'b100}, // XOR
      {7'h00, 3'b101}, // SRL
      {7'h20, 3'b101}, // SRA
      {7'h00, 3'b110}, // OR
      {7'h00, 3'b111}: // AND
        r_legal = 1'b1;
      default: r_legal = 1'b0;
    endcase
  end

  // A branch offset must be even and fit a 13-bit signed field
  // (-4096..4094). That holds when bits 31..12 are all equal.
  assign b_f3_ok   = (in_funct[2:0] != 3'b010) && (in_funct[2:0] != 3'b011);
  assign b_off_ok  = !in_offset[0] &&
                     ((in_offset[31:12] == 20'h00000) || (in_offset[31:12] == 20'hFFFFF));
  assign req_legal = in_kind ? (b_f3_ok && b_off_ok) : r_legal;

  assign imm      = in_offset[12:0];
  assign r_word   = {in_funct[9:3], in_rs2, in_rs1, in_funct[2:0], in_rd, 7'b0110011};
  assign b_word   = {imm[12], imm[10:5], in_rs2, in_rs1, in_funct[2:0], imm[4:1], imm[11],
                     7'b1100011};
  assign enc_word = in_kind ? b_word : r_word;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_instr = instr0_q;
  assign out_addr  = addr0_q;
  assign err       = err_q;
  assign err_count = err_count_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && req_legal;
  assign pop    = out_valid && out_ready;

  // FIFO next state: pop shifts slot 1 into the head, then a push fills the first free slot.
  always_comb begin
    count_d  = count_q;
    instr0_d = instr0_q;
    instr1_d = instr1_q;
    addr0_d  = addr0_q;
    addr1_d  = addr1_q;
    fifo_n   = count_q;
    if (pop) begin
      instr0_d = instr1_q;
      addr0_d  = addr1_q;
      fifo_n   = fifo_n - 2'd1;
    end
    if (push) begin
      if (fifo_n == 2'd0) begin
        instr0_d = enc_word;
        addr0_d  = addr_cnt_q;
      end else begin
        instr1_d = enc_word;
        addr1_d  = addr_cnt_q;
      end
      fifo_n = fifo_n + 2'd1;
    end
    count_d = fifo_n;
  end

  // Address counter and error bookkeeping. A clear overrides the advance,
  // but a word pushed in the same cycle keeps the old address.
  always_comb begin
    addr_cnt_d  = addr_cnt_q;
    err_d       = accept && !req_legal;
    err_count_d = err_count_q;
    if (push) addr_cnt_d = addr_cnt_q + 32'd4;
    if (addr_clr) addr_cnt_d = BASE_ADDR;
    if (accept && !req_legal && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  // State registers. Reset empties the FIFO immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= 2'd0;
      instr0_q    <= 32'd0;
      instr1_q    <= 32'd0;
      addr0_q     <= 32'd0;
      addr1_q     <= 32'd0;
      addr_cnt_q  <= BASE_ADDR;
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      count_q     <= count_d;
      instr0_q    <= instr0_d;
      instr1_q    <= instr1_d;
      addr0_q     <= addr0_d;
      addr1_q     <= addr1_d;
      addr_cnt_q  <= addr_cnt_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Testbench for rv_instr_encoder: directed cases plus randomized streaming
// against a queue-based reference model built from the encoding rules.
module tb_rv_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        addr_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_kind = 1'b0;
  logic [9:0]  in_funct = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_offset = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_addr;
  logic        err;
  logic [7:0]  err_count;

  rv_instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .addr_clr(addr_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_funct(in_funct), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_offset(in_offset),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_count(err_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic [63:0] exp_q[$];          // {instr, addr} in acceptance order
  logic [31:0] model_addr = BASE;
  int          model_errcnt = 0;
  bit          err_pend = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          ready_mode = 0;    // 0: out_ready low, 1: high, 2: random

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {legal, word}, derived from the ISA field layout.
  function automatic logic [32:0] model_encode(input logic k, input logic [9:0] f,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] off);
    logic [9:0]  legal_r[10];
    logic [31:0] w, u, f3, f7;
    int          o;
    bit          legal;
    legal_r = '{10'h000, 10'h100, 10'h001, 10'h002, 10'h003,
                10'h004, 10'h005, 10'h105, 10'h006, 10'h007};
    f3 = 32'(f[2:0]);
    f7 = 32'(f[9:3]);
    if (!k) begin
      legal = 0;
      foreach (legal_r[i]) if (legal_r[i] == f) legal = 1;
      w = 32'h33 + (32'(rd) << 7) + (f3 << 12) + (32'(rs1) << 15) + (32'(rs2) << 20) + (f7 << 25);
    end else begin
      o = off;
      legal = (f3 != 2) && (f3 != 3) && ((o % 2) == 0) && (o >= -4096) && (o <= 4094);
      u = off & 32'h1FFF;
      w = 32'h63 | (((u >> 11) & 1) << 7) | (((u >> 1) & 15) << 8) | (f3 << 12)
        | (32'(rs1) << 15) | (32'(rs2) << 20) | (((u >> 5) & 63) << 25)
        | (((u >> 12) & 1) << 31);
    end
    return {legal, w};
  endfunction

  // ---------------- scoreboard / monitor (samples at negedge) ----------------
  always @(negedge clk) begin
    logic [32:0] r;
    bit ready_m;
    if (!rst) begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      if (exp_q.size() != 0 && out_valid) check("head", {out_instr, out_addr}, exp_q[0]);
      check("err", 64'(err), 64'(err_pend));
      check("err_count", 64'(err_count), 64'(model_errcnt));
      ready_m = (exp_q.size() < 2);
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      err_pend = 0;
      if (in_valid && ready_m) begin
        r = model_encode(in_kind, in_funct, in_rd, in_rs1, in_rs2, in_offset);
        if (r[32]) begin
          exp_q.push_back({r[31:0], model_addr});
          model_addr = model_addr + 32'd4;
        end else begin
          err_pend = 1;
          if (model_errcnt < 255) model_errcnt++;
        end
      end
      if (addr_clr) model_addr = BASE;
    end
  end

  // ---------------- out_ready driver ----------------
  always begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    model_addr = BASE;
    model_errcnt = 0;
    err_pend = 0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic k, input logic [9:0] f, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] off, input logic clr);
    bit done;
    int cyc;
    done = 0;
    cyc = 0;
    in_valid = 1'b1; in_kind = k; in_funct = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_offset = off; addr_clr = clr;
    while (!done && cyc < 200) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) check("send_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    addr_clr = 1'b0;
  endtask

  task automatic rand_send(input logic clr);
    logic [9:0]  f;
    logic [31:0] off;
    logic [9:0]  tbl[10];
    logic        k;
    tbl = '{10'h000, 10'h100, 10'h001, 10'h002, 10'h003,
            10'h004, 10'h005, 10'h105, 10'h006, 10'h007};
    k = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 9) < 8) f = tbl[$urandom_range(0, 9)];
    else f = 10'($urandom());
    if ($urandom_range(0, 3) != 0) off = 32'($urandom_range(0, 4095) * 2) - 32'd4096;
    else off = $urandom();
    send(k, f, 5'($urandom()), 5'($urandom()), 5'($urandom()), off, clr);
  endtask

  task automatic step_neg();
    @(negedge clk);
  endtask

  task automatic step_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int c;
    c = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && c < 100) begin
      step_pos();
      c++;
    end
    step_pos();
    step_pos();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1;
    do_reset();
    step_neg();
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_err_count", 64'(err_count), 64'd0);
    step_pos();

    // ADD rd=3 rs1=1 rs2=2
    ready_mode = 0;
    step_pos();
    send(1'b0, 10'h000, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    step_neg();
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_word", {out_instr, out_addr}, {32'h002081B3, BASE});
    step_pos();
    drain();

    // SUB then BEQ with the consumer stalled
    do_reset();
    ready_mode = 0;
    step_pos();
    send(1'b0, 10'h100, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0);
    send(1'b1, 10'h000, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    step_neg();
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("sub_word", {out_instr, out_addr}, {32'h407302B3, BASE});
    ready_mode = 1;
    repeat (2) @(posedge clk);
    step_neg();
    check("beq_word", {out_instr, out_addr}, {32'h00208463, BASE + 32'd4});
    step_pos();
    drain();

    // BNE with negative offset
    ready_mode = 0;
    step_pos();
    send(1'b1, 10'h001, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0);
    step_neg();
    check("bne_instr", 64'(out_instr), 64'h0000_0000_FE00_1EE3);
    step_pos();
    drain();

    // offset boundaries
    send(1'b1, 10'h000, 5'd0, 5'd1, 5'd2, 32'd4094, 1'b0);
    send(1'b1, 10'h000, 5'd0, 5'd1, 5'd2, 32'd4096, 1'b0);
    step_neg();
    check("off_4096_err", 64'(err), 64'd1);
    step_pos();
    send(1'b1, 10'h000, 5'd0, 5'd1, 5'd2, 32'hFFFF_EFFE, 1'b0);
    send(1'b1, 10'h000, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
    send(1'b1, 10'h000, 5'd0, 5'd1, 5'd2, 32'hFFFF_F000, 1'b0);
    drain();

    // illegal function codes and counter saturation
    do_reset();
    step_pos();
    send(1'b0, 10'h101, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
    send(1'b1, 10'h002, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
    step_neg();
    check("err_count_2", 64'(err_count), 64'd2);
    step_pos();
    for (int i = 0; i < 300; i++) send(1'b0, 10'h3FF, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    step_neg();
    check("err_count_sat", 64'(err_count), 64'd255);
    step_pos();

    // randomized streaming
    do_reset();
    ready_mode = 2;
    step_pos();
    for (int i = 0; i < 1000; i++) begin
      rand_send(1'($urandom_range(0, 49) == 0));
      if ($urandom_range(0, 63) == 0) begin
        addr_clr = 1'b1;
        step_pos();
        addr_clr = 1'b0;
      end
    end
    drain();

    // addr_clr together with a legal request
    send(1'b0, 10'h007, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    send(1'b0, 10'h006, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    send(1'b0, 10'h004, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    step_neg();
    check("clr_addr", 64'(out_addr), 64'(BASE));
    step_pos();
    drain();

    // reset with two entries queued
    ready_mode = 0;
    step_pos();
    send(1'b0, 10'h000, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    send(1'b0, 10'h000, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0);
    do_reset();
    ready_mode = 1;
    step_pos();
    send(1'b0, 10'h000, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    step_neg();
    check("post_rst_addr", 64'(out_addr), 64'(BASE));
    step_pos();
    drain();

    check("final_empty", 64'(out_valid), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
